gmux_ce_sel: RTL and testbench
==============================

Name: gmux_ce_sel

Overview:
- Parametrised N-way clock-enable selector; successor to the two-input combinational clock mux.
- Runs entirely in one clock domain. Selects one of N clock-enable strobes (divided-clock enables generated from CLK) onto a single output enable.
- Switches sources with a request/acknowledge handshake at phase-safe boundaries, so the output never produces a truncated enable period.
- Sits between the enable generators and the downstream clock-enabled fabric.

Parameters:
- N, 4, number of enable sources (2..16).
- SEL_W, 2, select width; must be at least ceil(log2(N)).
- INIT_SEL, 0, source selected after reset.
- TIMEOUT, 1024, maximum cycles spent in DRAIN plus SYNC before a forced switch (at least 2).

Ports:
- CLK  input  1  single clock; all logic is rising-edge.
- RST  input  1  synchronous, active-high reset.
- CE_IN  input  N  per-source enable strobes, synchronous to CLK.
- SEL_IN  input  SEL_W  requested source index.
- REQ  input  1  switch request; sampled only when BUSY=0.
- CE_OUT  output  1  selected enable, registered.
- ACK  output  1  one-cycle pulse when a request completes.
- SEL_CUR  output  SEL_W  currently selected source.
- BUSY  output  1  high while a switch is in progress.
- ERR  output  1  sticky error flag; cleared by RST or by the next accepted REQ.

Behaviour:
- Reset, in the cycle after RST is sampled high:
  - CE_OUT=0, ACK=0, BUSY=0, ERR=0, SEL_CUR=INIT_SEL, state RUN, timeout counter 0.
  - RST asserted mid-switch aborts the switch; no ACK is issued.
- Latency: in RUN, CE_OUT(t+1) = CE_IN[SEL_CUR](t). Fixed 1-cycle latency.
- States: RUN, DRAIN, SYNC. BUSY=1 in DRAIN and SYNC.
- RUN:
  - REQ=1 with SEL_IN == SEL_CUR: ACK next cycle, no state change, no disruption to CE_OUT.
  - REQ=1 with SEL_IN >= N: ACK next cycle, ERR=1, SEL_CUR unchanged.
  - REQ=1 with a valid, different SEL_IN: latch it as NXT, clear ERR, go to DRAIN. A CE_IN[SEL_CUR] pulse in the acceptance cycle is still passed normally.
- DRAIN:
  - Continue passing CE_IN[SEL_CUR].
  - On the first CE_IN[SEL_CUR]=1, pass that pulse and go to SYNC.
- SYNC:
  - CE_OUT forced to 0.
  - On the first CE_IN[NXT]=1: swallow that pulse (it marks the phase boundary), set SEL_CUR=NXT, ACK=1 next cycle, go to RUN.
  - The next CE_IN[NXT] pulse is emitted normally.
  - Guarantee: the output gap across a switch is at least one full new-source period.
  - A CE_IN[NXT] pulse in the same cycle as the last old pulse (DRAIN exit) does not count as the boundary.
- Timeout:
  - Counter increments each cycle in DRAIN or SYNC and clears in RUN.
  - When it reaches TIMEOUT-1 (still in DRAIN or SYNC): SEL_CUR=NXT, ERR=1, ACK pulse, go to RUN. CE_OUT=0 in that cycle.
- REQ while BUSY=1 is ignored; there is no queueing. The requester holds REQ until ACK; ACK is a single pulse.
- A source with CE_IN held constantly high is legal: DRAIN exits in 1 cycle, SYNC in 1 cycle.
- SEL_IN is sampled only in the acceptance cycle.

Test Plan:
- Reset and steady run: N=4, CE_IN[0] every 4 cycles, RST for 2 cycles, then 20 cycles -> CE_OUT pulses 1 cycle after each CE_IN[0]; BUSY=0, ACK=0, SEL_CUR=0 throughout.
- Clean switch 0->2:
  - Stimulus: src0 period 4, src2 period 6; REQ with SEL_IN=2 one cycle after a src0 pulse.
  - Required: the next src0 pulse is emitted; the first src2 pulse is swallowed; ACK and SEL_CUR=2; the second src2 pulse is emitted.
  - Measured output gap across the switch is at least 6.
- Same-select and bad select:
  - REQ with SEL_IN=0 while on 0 -> ACK next cycle, CE_OUT cadence unchanged.
  - REQ with SEL_IN=5 -> ACK, ERR=1, SEL_CUR=0.
  - A following valid REQ clears ERR.
- Timeout: TIMEOUT=16, REQ with SEL_IN=3 while CE_IN[3] is stuck at 0 -> ACK and ERR=1 exactly 16 cycles after acceptance; SEL_CUR=3; CE_OUT=0 throughout SYNC.
- Boundary coincidence: CE_IN[SEL_CUR] and CE_IN[NXT] both pulse in the same cycle while in DRAIN -> old pulse emitted, new pulse not counted; the switch completes on the next new-source pulse.
- Reset mid-switch: RST asserted while in SYNC -> next cycle SEL_CUR=INIT_SEL, BUSY=0, no ACK; later REQ accepted normally.

Source files
------------

// File: rtl/gmux_ce_sel.sv
// gmux_ce_sel: N-way clock-enable selector with a phase-safe switch handshake.
// A switch drains the old source up to its next strobe, then waits for the
// first strobe of the new source (swallowed as the phase marker). The output
// therefore never carries a truncated enable period. A timeout forces the
// switch when a source stalls.
module gmux_ce_sel #(
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int INIT_SEL = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     CE_IN,
    input  logic [SEL_W-1:0] SEL_IN,
    input  logic             REQ,
    output logic             CE_OUT,
    output logic             ACK,
    output logic [SEL_W-1:0] SEL_CUR,
    output logic             BUSY,
    output logic             ERR
);

    // Pad the strobes to the full select range so any SEL_W-bit index is legal.
    localparam int PW = 1 << SEL_W;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {RUN, DRAIN, SYNC} state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] nxt, nxt_n, sel_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ce_n, ack_n, err_n;
    logic [PW-1:0]    ce_pad;
    logic             ce_cur, ce_nxt, sel_bad, timeout;

    assign ce_pad  = PW'(CE_IN);
    assign ce_cur  = ce_pad[SEL_CUR];
    assign ce_nxt  = ce_pad[nxt];
    assign sel_bad = 32'(SEL_IN) >= N;
    assign timeout = (cnt == CW'(TIMEOUT - 1));
    assign BUSY    = (state != RUN);

    // Next-state, next-output and switch bookkeeping.
    always_comb begin
        state_n = state;
        sel_n   = SEL_CUR;
        nxt_n   = nxt;
        ce_n    = 1'b0;
        ack_n   = 1'b0;
        err_n   = ERR;
        case (state)
            RUN: begin
                ce_n = ce_cur;
                if (REQ) begin
                    if (SEL_IN == SEL_CUR) begin
                        ack_n = 1'b1;
                        err_n = 1'b0;
                    end else if (sel_bad) begin
                        ack_n = 1'b1;
                        err_n = 1'b1;
                    end else begin
                        nxt_n   = SEL_IN;
                        err_n   = 1'b0;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (timeout) begin
                    // Forced switch: output held low this cycle.
                    sel_n   = nxt;
                    err_n   = 1'b1;
                    ack_n   = 1'b1;
                    state_n = RUN;
                end else begin
                    // Old source keeps running until its next strobe, which is
                    // passed; a new-source strobe here is not a boundary.
                    ce_n = ce_cur;
                    if (ce_cur) state_n = SYNC;
                end
            end
            SYNC: begin
                // Output silent; the first new-source strobe marks the phase
                // boundary and is swallowed.
                if (timeout || ce_nxt) begin
                    sel_n   = nxt;
                    ack_n   = 1'b1;
                    state_n = RUN;
                    if (timeout) err_n = 1'b1;
                end
            end
            default: state_n = RUN;
        endcase
        // Counter only runs across consecutive busy cycles.
        if (state == RUN || state_n == RUN) cnt_n = '0;
        else                                cnt_n = cnt + 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            SEL_CUR <= SEL_W'(INIT_SEL);
            nxt     <= SEL_W'(INIT_SEL);
            cnt     <= '0;
            CE_OUT  <= 1'b0;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_n;
            SEL_CUR <= sel_n;
            nxt     <= nxt_n;
            cnt     <= cnt_n;
            CE_OUT  <= ce_n;
            ACK     <= ack_n;
            ERR     <= err_n;
        end
    end

endmodule

// File: tb/tb_gmux_ce_sel.sv
// Directed bench for gmux_ce_sel: N=4, SEL_W=3 (so out-of-range selects are
// expressible), TIMEOUT=16. Each cycle the observed tuple
// {CE_OUT,ACK,BUSY,ERR,SEL_CUR} is compared with a hand-derived value.
module tb_gmux_ce_sel;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] CE_IN = '0;
    logic [2:0] SEL_IN = '0;
    logic       REQ = 1'b0;
    logic       CE_OUT, ACK, BUSY, ERR;
    logic [2:0] SEL_CUR;
    logic [6:0] obs, exp_v;
    int         nvec = 0;
    int         nmis = 0;

    gmux_ce_sel #(.N(4), .SEL_W(3), .INIT_SEL(0), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .CE_IN(CE_IN), .SEL_IN(SEL_IN), .REQ(REQ),
        .CE_OUT(CE_OUT), .ACK(ACK), .SEL_CUR(SEL_CUR), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    assign obs = {CE_OUT, ACK, BUSY, ERR, SEL_CUR};

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic [3:0] ce, input logic req, input logic [2:0] sel,
                       input logic rst);
        CE_IN  = ce;
        REQ    = req;
        SEL_IN = sel;
        RST    = rst;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            cyc(4'b1111, 1'b1, 3'd2, 1'b1);
            exp_v = 7'b0;
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL reset cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_steady;
        logic [3:0] ce;
        for (int k = 0; k < 20; k++) begin
            ce = '0;
            ce[0] = (k % 4 == 0);
            cyc(ce, 1'b0, 3'd0, 1'b0);
            exp_v = {(k % 4 == 0), 1'b0, 1'b0, 1'b0, 3'd0};
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL steady cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_switch;
        logic [3:0] ce;
        int t_old = -100;
        int t_new = -1;
        for (int k = 0; k < 18; k++) begin
            ce = '0;
            ce[0] = (k % 4 == 0);
            ce[2] = (k % 6 == 3);
            cyc(ce, (k >= 1 && k <= 9), 3'd2, 1'b0);
            exp_v = {(k == 0 || k == 4 || k == 15), (k == 9), (k >= 1 && k <= 8), 1'b0,
                     (k >= 9) ? 3'd2 : 3'd0};
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL clean_switch cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", k, obs, exp_v);
            end
            if (CE_OUT === 1'b1) begin
                if (SEL_CUR === 3'd0) t_old = k;
                else if (t_new < 0) t_new = k;
            end
        end
        nvec++;
        if (t_new < 0 || (t_new - t_old) < 6) begin
            nmis++;
            $display("FAIL switch_gap: got %0d cycles expected at least 6", t_new - t_old);
        end
    endtask

    task automatic test_select_checks;
        logic [3:0] ce;
        logic       req;
        logic [2:0] sel;
        for (int j = 0; j < 20; j++) begin
            ce = '0;
            ce[2] = (j % 6 == 0);
            ce[0] = (j % 4 == 2);
            req = 1'b0;
            sel = 3'd0;
            if (j == 1)                begin req = 1'b1; sel = 3'd2; end
            if (j == 8)                begin req = 1'b1; sel = 3'd5; end
            if (j >= 10 && j <= 14)    begin req = 1'b1; sel = 3'd0; end
            cyc(ce, req, sel, 1'b0);
            exp_v = {(j == 0 || j == 6 || j == 12 || j == 18), (j == 1 || j == 8 || j == 14),
                     (j >= 10 && j <= 13), (j == 8 || j == 9), (j >= 14) ? 3'd0 : 3'd2};
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL select_checks cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout;
        logic [3:0] ce;
        for (int j = 0; j < 18; j++) begin
            ce = '0;
            ce[0] = (j % 4 == 1);
            cyc(ce, (j <= 16), 3'd3, 1'b0);
            exp_v = {(j == 1), (j == 16), (j <= 15), (j >= 16), (j >= 16) ? 3'd3 : 3'd0};
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL timeout cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_coincidence;
        logic [3:0] ce;
        for (int j = 0; j < 10; j++) begin
            ce = '0;
            ce[3] = (j == 2 || j == 6);
            ce[1] = (j == 2 || j == 5 || j == 8);
            cyc(ce, (j <= 5), 3'd1, 1'b0);
            exp_v = {(j == 2 || j == 8), (j == 5), (j <= 4), 1'b0, (j >= 5) ? 3'd1 : 3'd3};
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL coincidence cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_switch;
        logic [3:0] ce;
        logic       req;
        logic [2:0] sel;
        for (int j = 0; j < 14; j++) begin
            ce = '0;
            ce[1] = (j == 1 || j == 10 || j == 13);
            ce[0] = (j == 8);
            req = 1'b0;
            sel = 3'd0;
            if (j <= 3)             begin req = 1'b1; sel = 3'd2; end
            if (j >= 7 && j <= 10)  begin req = 1'b1; sel = 3'd1; end
            cyc(ce, req, sel, (j == 3));
            exp_v = {(j == 1 || j == 8 || j == 13), (j == 10),
                     (j <= 2 || (j >= 7 && j <= 9)), 1'b0,
                     (j <= 2 || j >= 10) ? 3'd1 : 3'd0};
            nvec++;
            if (obs !== exp_v) begin
                nmis++;
                $display("FAIL reset_mid_switch cyc=%0d {ce,ack,busy,err,sel}: got %b expected %b", j, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_clean_switch();
        test_select_checks();
        test_timeout();
        test_coincidence();
        test_reset_mid_switch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
